// File: rtl/pipelined_carry_select_adder_if.sv
// Operand/result bundle for the pipelined carry-select adder.
//   master : issuing side. Drives valid/stall/subtract/operands/carry-in and
//            receives result, carry, overflow, zero and valid_o.
//   slave  : the adder. Sees the same signals with directions reversed.
// Clock and reset are not part of the bundle; they stay plain module ports.
interface pipelined_carry_select_adder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  stall_i;
  logic                  subtract_i;
  logic [DATA_WIDTH-1:0] operand_A_i;
  logic [DATA_WIDTH-1:0] operand_B_i;
  logic                  carry_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  carry_o;
  logic                  overflow_o;
  logic                  zero_o;
  logic                  valid_o;

  modport master (
    output valid_i, stall_i, subtract_i, operand_A_i, operand_B_i, carry_i,
    input  result_o, carry_o, overflow_o, zero_o, valid_o
  );

  modport slave (
    input  valid_i, stall_i, subtract_i, operand_A_i, operand_B_i, carry_i,
    output result_o, carry_o, overflow_o, zero_o, valid_o
  );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor.
// The operands are split into BLOCK_WIDTH-bit carry-select blocks and
// BLOCKS_PER_STAGE blocks are resolved per pipeline stage, so a result takes
// NUM_STAGES = DATA_WIDTH / (BLOCK_WIDTH * BLOCKS_PER_STAGE) cycles. The last
// stage's register is the output register, which also holds the flags.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset, clears every register
//   io      slave side of pipelined_carry_select_adder_if:
//           valid_i/stall_i/subtract_i/operand_A_i/operand_B_i/carry_i in,
//           result_o/carry_o/overflow_o/zero_o/valid_o out
module pipelined_carry_select_adder #(
  parameter int DATA_WIDTH       = 32,
  parameter int BLOCK_WIDTH      = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  pipelined_carry_select_adder_if.slave io
);
  localparam int CSA_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;
  localparam int NUM_STAGES = CSA_BLOCKS / BLOCKS_PER_STAGE;
  localparam int SW         = BLOCK_WIDTH * BLOCKS_PER_STAGE;  // bits per stage
  localparam int LS         = NUM_STAGES - 1;

  // Subtraction is A + ~B + ~borrow, so carry_o = 1 means "no borrow".
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  cin_eff;
  logic                  advance;

  assign b_eff   = io.subtract_i ? ~io.operand_B_i : io.operand_B_i;
  assign cin_eff = io.subtract_i ? ~io.carry_i     : io.carry_i;
  // A stall freezes every register in the pipe at once, so no operation can
  // be lost or duplicated across it.
  assign advance = ~io.stall_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO_W = k * SW;             // result bits finished upstream
    localparam int HI_W = DATA_WIDTH - LO_W;  // operand bits still pending

    logic [HI_W-1:0]           a_in, b_in;
    logic                      c_in, v_in;
    logic [SW-1:0]             sum;
    logic [BLOCKS_PER_STAGE:0] c_chain;
    logic [LO_W+SW-1:0]        done;          // all result bits known so far

    if (k == 0) begin : g_src
      assign a_in = io.operand_A_i;
      assign b_in = b_eff;
      assign c_in = cin_eff;
      assign v_in = io.valid_i;
      assign done = sum;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_reg.a_q;
      assign b_in = g_stage[k-1].g_reg.b_q;
      assign c_in = g_stage[k-1].g_reg.c_q;
      assign v_in = g_stage[k-1].g_reg.v_q;
      assign done = {sum, g_stage[k-1].g_reg.res_q};
    end

    assign c_chain[0] = c_in;

    for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
      logic [BLOCK_WIDTH-1:0] a_s, b_s;
      logic [BLOCK_WIDTH:0]   s0, s1;

      assign a_s = a_in[j*BLOCK_WIDTH +: BLOCK_WIDTH];
      assign b_s = b_in[j*BLOCK_WIDTH +: BLOCK_WIDTH];

      if (k == 0 && j == 0) begin : g_rip
        // The lowest block has its real carry-in up front: plain ripple.
        assign s0 = {1'b0, a_s} + {1'b0, b_s} + {{BLOCK_WIDTH{1'b0}}, c_chain[0]};
        assign s1 = s0;
      end else begin : g_sel
        assign s0 = {1'b0, a_s} + {1'b0, b_s};
        assign s1 = {1'b0, a_s} + {1'b0, b_s} + {{BLOCK_WIDTH{1'b0}}, 1'b1};
      end

      assign {c_chain[j+1], sum[j*BLOCK_WIDTH +: BLOCK_WIDTH]} = c_chain[j] ? s1 : s0;
    end

    if (k < LS) begin : g_reg
      localparam int NX_W = HI_W - SW;

      // res_q de-skews finished low slices; a_q/b_q skew the unprocessed
      // upper slices, which also carry the operand sign bits to the end.
      // Data regs load even under a bubble; v_q qualifies them.
      logic [LO_W+SW-1:0] res_d, res_q;
      logic [NX_W-1:0]    a_d, a_q, b_d, b_q;
      logic               c_d, c_q, v_d, v_q;

      always_comb begin
        res_d = res_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        v_d   = v_q;
        if (advance) begin
          res_d = done;
          a_d   = a_in[HI_W-1:SW];
          b_d   = b_in[HI_W-1:SW];
          c_d   = c_chain[BLOCKS_PER_STAGE];
          v_d   = v_in;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          res_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
        end else begin
          res_q <= res_d;
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= c_d;
          v_q   <= v_d;
        end
      end
    end
  end

  // Output register = register of the final stage, flags included.
  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic                  carry_d, carry_q;
  logic                  ovf_d, ovf_q;
  logic                  zero_d, zero_q;
  logic                  valid_d, valid_q;
  logic                  a_msb, b_msb;

  assign a_msb = g_stage[LS].a_in[SW-1];
  assign b_msb = g_stage[LS].b_in[SW-1];

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    if (advance) begin
      result_d = g_stage[LS].done;
      carry_d  = g_stage[LS].c_chain[BLOCKS_PER_STAGE];
      // Same-signed addends whose sum flips sign have overflowed.
      ovf_d    = (a_msb == b_msb) && (g_stage[LS].done[DATA_WIDTH-1] != a_msb);
      zero_d   = ~|g_stage[LS].done;
      valid_d  = g_stage[LS].v_in;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign io.result_o   = result_q;
  assign io.carry_o    = carry_q;
  assign io.overflow_o = ovf_q;
  assign io.zero_o     = zero_q;
  assign io.valid_o    = valid_q;
endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor for the integer execution unit. It splits the operands into BLOCK_WIDTH carry-select blocks and groups BLOCKS_PER_STAGE blocks per pipeline stage, so wide adds close timing at high clock rates. Each operation travels with a valid bit, and the pipeline can be frozen by a stall. It also produces carry, signed-overflow and zero flags for the ALU and branch logic.

Parameters:
DATA_WIDTH, 32, operand/result width; must be a multiple of BLOCK_WIDTH
BLOCK_WIDTH, 4, bits per carry-select block (block 0 is a plain ripple block)
BLOCKS_PER_STAGE, 2, blocks evaluated per pipeline stage; CSA_BLOCKS = DATA_WIDTH/BLOCK_WIDTH must be divisible by it

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  operation present on inputs
stall_i  in  1  freeze entire pipeline
subtract_i  in  1  0 = A+B+carry_i, 1 = A-B-carry_i (carry_i is borrow-in)
operand_A_i  in  DATA_WIDTH  first operand
operand_B_i  in  DATA_WIDTH  second operand
carry_i  in  1  carry-in (add) / borrow-in (sub)
result_o  out  DATA_WIDTH  sum/difference
carry_o  out  1  carry-out of MSB; for sub, 1 = no borrow
overflow_o  out  1  two's-complement signed overflow
zero_o  out  1  result_o == 0
valid_o  out  1  outputs hold a completed operation

Behaviour:
- Clock is clk_i. rst_i is asynchronous and active-high.
- Reset (async assert): all stage valid bits, data, carries and outputs go to 0 immediately. Release takes effect on the next clock edge.
- Operand conditioning:
  - B_eff = subtract_i ? ~operand_B_i : operand_B_i
  - cin_eff = subtract_i ? ~carry_i : carry_i
  - The adder computes A + B_eff + cin_eff.
- NUM_STAGES = CSA_BLOCKS / BLOCKS_PER_STAGE. Latency is exactly NUM_STAGES cycles from an accepted input to valid_o. With defaults: 8 blocks, 4 stages, latency 4.
- Stage k:
  - Computes blocks k*BLOCKS_PER_STAGE .. (k+1)*BLOCKS_PER_STAGE-1 using the carry registered at the end of stage k-1. Stage 0 uses cin_eff.
  - Each block computes both carry-0 and carry-1 results and muxes them on the incoming carry.
  - Registers its partial result, the still-unprocessed upper operand slices (skew registers), the outgoing carry, valid and the MSB operand signs needed for overflow.
  - Already-computed lower result slices are forwarded unchanged (de-skew).
- Output stage (registered):
  - result_o is the concatenation of all slices.
  - carry_o is the final block carry-out.
  - overflow_o = (A[MSB] == B_eff[MSB]) && (result[MSB] != A[MSB]).
  - zero_o = ~|result_o.
- Handshake:
  - Input is accepted on a rising edge when valid_i && !stall_i.
  - valid_i while stalled is ignored and not buffered; the upstream must hold it.
  - A bubble (valid_i = 0) propagates as valid = 0. Data registers may update freely under a bubble, but valid_o = 0 qualifies them.
  - Throughput is one operation per cycle with no stall. Results emerge strictly in issue order.
- Stall: when stall_i = 1, every pipeline register holds, including outputs and valid_o, for as many cycles as stall_i is high. Release resumes with no lost or duplicated operation.
- Simultaneous reset and stall: reset wins.
- Reset mid-operation: all in-flight operations are discarded. valid_o = 0 until a new operation completes NUM_STAGES cycles after its acceptance.
- Wrap-around: the sum is modulo 2^DATA_WIDTH. The carry is reported only on carry_o.
- Flag values (carry_o, overflow_o, zero_o) are meaningful only when valid_o = 1. Reset values are 0.

Test Plan:
1. Reset: assert rst_i asynchronously mid-cycle -> result_o = 0, all flags = 0, valid_o = 0 immediately. Valid is first observed 4 cycles after the first accepted op.
2. Add wrap: A = 0xFFFFFFFF, B = 0x00000001, carry_i = 0, subtract_i = 0 -> after 4 cycles result_o = 0x00000000, carry_o = 1, zero_o = 1, overflow_o = 0. Then A = 0x7FFFFFFF, B = 1 -> 0x80000000, overflow_o = 1, carry_o = 0.
3. Subtract:
   - 5 - 7, carry_i = 0 -> 0xFFFFFFFE, carry_o = 0, overflow_o = 0.
   - 0x80000000 - 1 -> 0x7FFFFFFF, carry_o = 1, overflow_o = 1.
   - 10 - 3 with borrow carry_i = 1 -> 0x00000006, carry_o = 1.
4. Back-to-back: issue 4 consecutive ops (1+1, 2+2, 0x0F+0x01, 0xFFFF+1) -> cycles 4..7 show 2, 4, 0x10, 0x10000 in order, with valid_o high each cycle. Insert one bubble -> exactly one valid_o = 0 gap at the matching cycle.
5. Stall: issue 3 ops, raise stall_i for 3 cycles at cycle 2 -> all outputs frozen during the stall. Results appear at cycles 7, 8, 9 in order. A valid_i pulse presented only during the stall is never output.
6. Reset mid-flight: issue 3 ops, pulse rst_i at cycle 2 -> valid_o stays 0 with no stale results. A new op 3+4 issued after release returns 7 exactly 4 cycles later. Repeat with DATA_WIDTH = 64, BLOCK_WIDTH = 8, BLOCKS_PER_STAGE = 4 (latency 2) against a random reference model.
